// File: rtl/mem_ctrl_if.sv
// CPU-side request/response bus of the memory/I-O access controller.
// req is held with stable fields until the one-cycle ack; rdata is valid while ack=1.
interface mem_ctrl_if #(
  parameter int data_width = 16,
  parameter int addr_width = 8
);
  logic                  req;
  logic                  req_write;
  logic [addr_width:0]   req_addr;
  logic [data_width-1:0] req_wdata;
  logic                  ack;
  logic [data_width-1:0] rdata;

  modport master (
    output req, req_write, req_addr, req_wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, req_write, req_addr, req_wdata,
    output ack, rdata
  );
endinterface

// File: rtl/mem_ctrl.sv
// Memory/I-O access controller: decodes CPU requests into RAM or memory-mapped I/O
// and sequences the RAM's registered read and write-suppresses-read behaviour.
module mem_ctrl #(
  parameter int data_width = 16,
  parameter int addr_width = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_ctrl_if.slave             bus,
  output logic [addr_width-1:0] ram_read_address,
  output logic [addr_width-1:0] ram_write_address,
  output logic                  ram_write,
  output logic [data_width-1:0] ram_din,
  input  logic [data_width-1:0] ram_dout,
  input  logic [7:0]            sw,
  output logic [7:0]            led,
  output logic [2:0]            state_dbg
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] RESP = 3'd4;

  localparam logic [addr_width:0] led_addr = {1'b1, {addr_width{1'b0}}};
  localparam logic [addr_width:0] sw_addr  = led_addr | (addr_width+1)'(64);

  logic [2:0]            state;
  logic [addr_width:0]   addr_q;
  logic [data_width-1:0] wdata_q;
  logic                  write_q;
  logic [data_width-1:0] io_rdata;

  assign state_dbg         = state;
  assign ram_read_address  = addr_q[addr_width-1:0];
  assign ram_write_address = addr_q[addr_width-1:0];
  assign ram_din           = wdata_q;
  // write_q is always set in WR; qualifying on it keeps the latched direction meaningful.
  assign ram_write         = (state == WR) && write_q && !reset;

  always_comb begin
    io_rdata = '0;
    if (bus.req_addr == led_addr)
      io_rdata = {{(data_width-8){1'b0}}, led};
    else if (bus.req_addr == sw_addr)
      io_rdata = {{(data_width-8){1'b0}}, sw};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bus.ack   <= 1'b0;
      bus.rdata <= '0;
      led       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req) begin
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            write_q <= bus.req_write;
            if (!bus.req_addr[addr_width]) begin
              state <= bus.req_write ? WR : RD;
            end else begin
              // I/O completes on the accepting edge; unmapped writes are dropped.
              if (bus.req_write) begin
                if (bus.req_addr == led_addr)
                  led <= bus.req_wdata[7:0];
              end else begin
                bus.rdata <= io_rdata;
              end
              bus.ack <= 1'b1;
              state   <= RESP;
            end
          end
        end
        RD: state <= WAIT;
        WAIT: begin
          bus.rdata <= ram_dout;
          bus.ack   <= 1'b1;
          state     <= RESP;
        end
        WR: begin
          bus.ack <= 1'b1;
          state   <= RESP;
        end
        RESP: begin
          bus.ack <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          bus.ack <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: table of requests with expected read data, latency and LED value,
// plus sequences for reset during a RAM write and a continuously held request.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  ram_read_address, ram_write_address;
  logic        ram_write;
  logic [15:0] ram_din;
  logic [15:0] ram_dout = '0;
  logic [7:0]  sw = 8'h5A;
  logic [7:0]  led;
  logic [2:0]  state_dbg;

  mem_ctrl_if #(.data_width(16), .addr_width(8)) bus ();

  mem_ctrl #(.data_width(16), .addr_width(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .bus               (bus.slave),
    .ram_read_address  (ram_read_address),
    .ram_write_address (ram_write_address),
    .ram_write         (ram_write),
    .ram_din           (ram_din),
    .ram_dout          (ram_dout),
    .sw                (sw),
    .led               (led),
    .state_dbg         (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // synchronous single-port RAM: registered read, a write cycle suppresses the read
  logic [15:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = {8'hC0, 8'(i)};
  always @(posedge clk) begin
    if (ram_write) mem[ram_write_address] <= ram_din;
    else           ram_dout <= mem[ram_read_address];
  end

  int wr_cycles = 0;
  always @(negedge clk) if (ram_write) wr_cycles++;

  // scoreboard
  logic [15:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: one request, wait for ack (bounded), check latency, data and pulse width
  task automatic do_req(input logic wr, input logic [8:0] addr, input logic [15:0] wdata,
                        input logic [15:0] exp_rdata, input int exp_lat, input logic [7:0] exp_led);
    int cyc;
    int wr0;
    logic [15:0] e;
    @(negedge clk);
    bus.req = 1'b1; bus.req_write = wr; bus.req_addr = addr; bus.req_wdata = wdata;
    wr0 = wr_cycles;
    if (!wr) exp_q.push_back(exp_rdata);
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (!bus.ack && cyc < 10);
    bus.req = 1'b0;
    if (!bus.ack) begin
      check("ack_timeout", 32'(cyc), 32'(exp_lat));
      if (!wr) void'(exp_q.pop_front());
    end else begin
      check("latency", 32'(cyc), 32'(exp_lat));
      if (!wr) begin
        e = exp_q.pop_front();
        check("rdata", 32'(bus.rdata), 32'(e));
      end else begin
        check("rdata_hold", 32'(bus.rdata), 32'(exp_rdata));
      end
      check("led", 32'(led), 32'(exp_led));
    end
    @(posedge clk); #1;
    check("ack_width", 32'(bus.ack), 32'd0);
    check("ram_write_cycles", 32'(wr_cycles - wr0), (wr && !addr[8]) ? 32'd1 : 32'd0);
  endtask

  typedef struct {
    logic        wr;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    int          exp_lat;
    logic [7:0]  exp_led;
  } vec_t;

  vec_t vecs[14];
  int   n_ack;
  int   last_ack;

  initial begin
    vecs[0]  = '{1'b1, 9'h003, 16'h00A5, 16'h0000, 2, 8'h00};
    vecs[1]  = '{1'b0, 9'h003, 16'h0000, 16'h00A5, 3, 8'h00};
    vecs[2]  = '{1'b1, 9'h0FF, 16'h1234, 16'h00A5, 2, 8'h00};
    vecs[3]  = '{1'b1, 9'h000, 16'hBEEF, 16'h00A5, 2, 8'h00};
    vecs[4]  = '{1'b0, 9'h0FF, 16'h0000, 16'h1234, 3, 8'h00};
    vecs[5]  = '{1'b0, 9'h000, 16'h0000, 16'hBEEF, 3, 8'h00};
    vecs[6]  = '{1'b1, 9'h100, 16'hFF3C, 16'hBEEF, 1, 8'h3C};
    vecs[7]  = '{1'b0, 9'h100, 16'h0000, 16'h003C, 1, 8'h3C};
    vecs[8]  = '{1'b0, 9'h140, 16'h0000, 16'h005A, 1, 8'h3C};
    vecs[9]  = '{1'b1, 9'h140, 16'h1111, 16'h005A, 1, 8'h3C};
    vecs[10] = '{1'b0, 9'h1F0, 16'h0000, 16'h0000, 1, 8'h3C};
    vecs[11] = '{1'b1, 9'h1F0, 16'h2222, 16'h0000, 1, 8'h3C};
    vecs[12] = '{1'b0, 9'h0F0, 16'h0000, 16'hC0F0, 3, 8'h3C};
    vecs[13] = '{1'b0, 9'h003, 16'h0000, 16'h00A5, 3, 8'h3C};

    bus.req = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ack", 32'(bus.ack), 32'd0);
    check("reset_rdata", 32'(bus.rdata), 32'd0);
    check("reset_led", 32'(led), 32'd0);
    check("reset_ram_write", 32'(ram_write), 32'd0);
    check("reset_state", 32'(state_dbg), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++)
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata,
             vecs[i].exp_lat, vecs[i].exp_led);

    // reset lands while a RAM write to 0x10 is pending
    @(negedge clk);
    bus.req = 1'b1; bus.req_write = 1'b1; bus.req_addr = 9'h010; bus.req_wdata = 16'h7777;
    @(posedge clk); #1;
    check("wr_state", 32'(state_dbg), 32'd3);
    check("wr_ram_write", 32'(ram_write), 32'd1);
    @(negedge clk);
    reset = 1'b1; bus.req = 1'b0;
    #1;
    check("reset_blocks_write", 32'(ram_write), 32'd0);
    @(posedge clk); #1;
    check("mid_reset_ack", 32'(bus.ack), 32'd0);
    check("mid_reset_led", 32'(led), 32'd0);
    check("mid_reset_rdata", 32'(bus.rdata), 32'd0);
    check("mid_reset_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    n_ack = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.ack) n_ack++;
    end
    check("dropped_no_ack", 32'(n_ack), 32'd0);
    do_req(1'b0, 9'h010, 16'h0000, 16'hC010, 3, 8'h00);

    // req held high: one ack per read, 4 cycles apart
    @(negedge clk);
    bus.req = 1'b1; bus.req_write = 1'b0; bus.req_addr = 9'h005;
    n_ack = 0;
    last_ack = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (bus.ack) begin
        n_ack++;
        if (last_ack >= 0) check("ack_spacing", 32'(c - last_ack), 32'd4);
        check("held_rdata", 32'(bus.rdata), 32'hC005);
        last_ack = c;
      end
    end
    bus.req = 1'b0;
    check("held_ack_count", 32'(n_ack), 32'd5);
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory/I-O access controller between the CPU datapath and the synchronous single-port RAM. Accepts one request at a time from the CPU over a req/ack handshake and decodes a 9-bit CPU address into RAM space or memory-mapped I/O (LED register, switch input). It sequences the RAM's one-cycle registered read and its write-suppresses-read behaviour, returning read data with a single-cycle ack.

## Interface
- data_width, 16, data word width (matches RAM)
- addr_width, 8, RAM address width; CPU address is addr_width+1 bits
- clk  in  1  single clock; all state changes on posedge
- reset  in  1  synchronous, active-high
- req  in  1  request valid; held high with fields stable until ack
- req_write  in  1  1 = write, 0 = read
- req_addr  in  addr_width+1  CPU address
- req_wdata  in  data_width  write data
- ack  out  1  one-cycle completion pulse
- rdata  out  data_width  read result, valid while ack=1, held until next read completes
- ram_read_address  out  addr_width  to RAM
- ram_write_address  out  addr_width  to RAM
- ram_write  out  1  to RAM write enable
- ram_din  out  data_width  to RAM
- ram_dout  in  data_width  from RAM (registered, valid the cycle after address edge)
- sw  in  8  board switches
- led  out  8  LED register

## Operation
- Address map: req_addr[addr_width]=0 -> RAM at req_addr[addr_width-1:0]; 0x100 -> LED register (R/W, reads return {8'b0, led}); 0x140 -> switches (read {8'b0, sw}, writes ignored); any other I/O address: read returns 0, write ignored, still acked.
- Request fields latched into addr_q, wdata_q, write_q on the IDLE edge that accepts req.
- ram_read_address = ram_write_address = addr_q[addr_width-1:0]; ram_din = wdata_q.
- ram_write = (state==WR) && !reset; never high in any other state.
- States:
  - IDLE: req=1 & RAM & read -> RD; req=1 & RAM & write -> WR; req=1 & I/O -> perform access this edge (led <= wdata[7:0] or rdata <= I/O value), ack <= 1 -> RESP; req=0 stay.
  - RD: RAM captures mem[addr_q] this edge -> WAIT.
  - WAIT: rdata <= ram_dout, ack <= 1 -> RESP.
  - WR: RAM writes this edge; ack <= 1 -> RESP.
  - RESP: ack=1 for this cycle; ack <= 0 -> IDLE. req is ignored in RESP.
- Writes never modify rdata. led changes only on an I/O write to 0x100.

## Timing
- Edge E0 = IDLE edge at which req is accepted.
- RAM read: ack high in the cycle after E2 (latency 3 cycles from acceptance).
- RAM write: memory updated at E1, ack high in cycle after E1 (latency 2).
- I/O read/write: ack high in cycle after E0 (latency 1).
- ack exactly one cycle wide; earliest next acceptance is the IDLE edge after RESP, so back-to-back requests take latency+1 cycles each.
- CPU keeps req high through the ack cycle at most; req still high at the IDLE edge after RESP is a new request.
- Reset (any state, any cycle): state=IDLE, ack=0, rdata=0, led=0, addr_q=0, wdata_q=0, write_q=0; no RAM write on a reset edge; in-flight request is dropped without ack.
- RAM contents are not cleared by reset.

## Test plan
- Reset then RAM write 0x00A5 to 0x03, then read 0x03 -> write ack 2 cycles after acceptance; read ack 3 cycles after acceptance with rdata=0x00A5; ram_write high exactly one cycle.
- Write 0x1234 to 0x0FF, write 0xBEEF to 0x000, read both -> 0x1234 and 0xBEEF; no address aliasing across the RAM range ends.
- I/O: write 0xFF3C to 0x100 -> led=0x3C, ack 1 cycle later; read 0x100 -> 0x003C; sw=0x5A, read 0x140 -> 0x005A; write 0x140 -> led unchanged, ack still given.
- Unmapped 0x1F0: read -> rdata=0x0000 with ack; write -> no RAM write, led unchanged.
- Reset asserted in WR state with write 0x7777 to 0x10 pending -> no ack, ram_write low at that edge, subsequent read of 0x10 returns prior contents; led=0, rdata=0 after reset.
- req held high continuously with read of 0x05 -> one ack per transaction, spaced 4 cycles apart, never two consecutive ack cycles.
